// File: rtl/bcd_down_timer.sv
// Packed-BCD countdown timer: load a BCD start value, decrement once per enabled cycle, pulse done at expiry.
// Optional macro BCD_DOWN_TIMER_AUTO_RELOAD_EN restarts from the last loaded value on expiry.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   output logic [4*DIGITS-1:0]   count,
   output logic                  busy,
   output logic                  zero,
   output logic                  done
);

   typedef enum logic {EMPTY, ACTIVE} state_t;

   state_t               state;
   logic [4*DIGITS-1:0]  load_san;
   logic [4*DIGITS-1:0]  dec_val;
   logic                 expire;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
   logic [4*DIGITS-1:0]  reload;
`endif

   // Clamp invalid digits and build the rippled-borrow decrement in one pass.
   always_comb begin
      logic       borrow;
      logic [3:0] d;
      load_san = '0;
      dec_val  = '0;
      borrow   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = load_val[4*i +: 4];
         load_san[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
         d = count[4*i +: 4];
         if (!borrow) begin
            dec_val[4*i +: 4] = d;
         end else if (d == 4'd0) begin
            dec_val[4*i +: 4] = 4'd9;
         end else begin
            dec_val[4*i +: 4] = d - 4'd1;
            borrow = 1'b0;
         end
      end
   end

   assign expire = (state == ACTIVE) && en && (dec_val == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         count  <= '0;
         busy   <= 1'b0;
         zero   <= 1'b1;
         done   <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (load) begin
            count <= load_san;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
            reload <= load_san;
            // Expiry coinciding with a load still reports the period boundary.
            done   <= expire;
`endif
            if (load_san != '0) begin
               state <= ACTIVE;
               busy  <= 1'b1;
               zero  <= 1'b0;
            end else begin
               state <= EMPTY;
               busy  <= 1'b0;
               zero  <= 1'b1;
            end
         end else if (state == ACTIVE && en) begin
            if (expire) begin
               done <= 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
               if (reload != '0) begin
                  count <= reload;
               end else begin
                  count <= '0;
                  state <= EMPTY;
                  busy  <= 1'b0;
                  zero  <= 1'b1;
               end
`else
               count <= '0;
               state <= EMPTY;
               busy  <= 1'b0;
               zero  <= 1'b1;
`endif
            end else begin
               count <= dec_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer (DIGITS=2): vector table plus hand-written reset and reload sequences.
module tb_bcd_down_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] load_val;
   logic       en;
   logic [7:0] count;
   logic       busy;
   logic       zero;
   logic       done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       load;
      logic [7:0] load_val;
      logic       en;
      logic [7:0] cnt;
      logic       busy;
      logic       zero;
      logic       done;
   } vec_t;

   vec_t tbl[$];

   bcd_down_timer #(.DIGITS(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .count    (count),
      .busy     (busy),
      .zero     (zero),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(string nm, logic [7:0] c, logic b, logic z, logic d);
      chk({nm, ".count"}, count, c);
      chk({nm, ".busy"}, {7'd0, busy}, {7'd0, b});
      chk({nm, ".zero"}, {7'd0, zero}, {7'd0, z});
      chk({nm, ".done"}, {7'd0, done}, {7'd0, d});
   endtask

   task automatic add(logic l, logic [7:0] lv, logic e, logic [7:0] c, logic b, logic z, logic d);
      vec_t v;
      v.load = l; v.load_val = lv; v.en = e; v.cnt = c; v.busy = b; v.zero = z; v.done = d;
      tbl.push_back(v);
   endtask

   // Drive one cycle of inputs and return just after the capturing edge.
   task automatic cycle(logic l, logic [7:0] lv, logic e);
      load = l; load_val = lv; en = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Countdown from 12 to expiry, then hold in EMPTY.
      add(1, 8'h12, 0, 8'h12, 1, 0, 0);
      add(0, 8'h00, 1, 8'h11, 1, 0, 0);
      add(0, 8'h00, 1, 8'h10, 1, 0, 0);
      add(0, 8'h00, 1, 8'h09, 1, 0, 0);
      add(0, 8'h00, 1, 8'h08, 1, 0, 0);
      add(0, 8'h00, 1, 8'h07, 1, 0, 0);
      add(0, 8'h00, 1, 8'h06, 1, 0, 0);
      add(0, 8'h00, 1, 8'h05, 1, 0, 0);
      add(0, 8'h00, 1, 8'h04, 1, 0, 0);
      add(0, 8'h00, 1, 8'h03, 1, 0, 0);
      add(0, 8'h00, 1, 8'h02, 1, 0, 0);
      add(0, 8'h00, 1, 8'h01, 1, 0, 0);
      add(0, 8'h00, 1, 8'h00, 0, 1, 1);
      add(0, 8'h00, 1, 8'h00, 0, 1, 0);
      add(0, 8'h00, 1, 8'h00, 0, 1, 0);
      // Pause/resume: exactly five enabled cycles to expire.
      add(1, 8'h05, 0, 8'h05, 1, 0, 0);
      add(0, 8'h00, 1, 8'h04, 1, 0, 0);
      add(0, 8'h00, 0, 8'h04, 1, 0, 0);
      add(0, 8'h00, 1, 8'h03, 1, 0, 0);
      add(0, 8'h00, 0, 8'h03, 1, 0, 0);
      add(0, 8'h00, 1, 8'h02, 1, 0, 0);
      add(0, 8'h00, 0, 8'h02, 1, 0, 0);
      add(0, 8'h00, 1, 8'h01, 1, 0, 0);
      add(0, 8'h00, 0, 8'h01, 1, 0, 0);
      add(0, 8'h00, 1, 8'h00, 0, 1, 1);
      add(0, 8'h00, 0, 8'h00, 0, 1, 0);
      // Sanitizing, load-beats-enable, load of zero while active.
      add(1, 8'hAF, 0, 8'h99, 1, 0, 0);
      add(1, 8'h07, 1, 8'h07, 1, 0, 0);
      add(0, 8'h00, 1, 8'h06, 1, 0, 0);
      add(1, 8'h00, 1, 8'h00, 0, 1, 0);
      add(1, 8'h3C, 0, 8'h39, 1, 0, 0);
      // Borrow ripple across digits.
      add(1, 8'h40, 0, 8'h40, 1, 0, 0);
      add(0, 8'h00, 1, 8'h39, 1, 0, 0);
      add(1, 8'h10, 0, 8'h10, 1, 0, 0);
      add(0, 8'h00, 1, 8'h09, 1, 0, 0);
      add(1, 8'h00, 0, 8'h00, 0, 1, 0);

      reset = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b0;
      #3;
      chk_all("reset", 8'h00, 0, 1, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // No load: enable must never wrap below zero nor raise done.
      for (int i = 0; i < 20; i++) begin
         cycle(0, 8'h00, 1);
         chk_all($sformatf("idle%0d", i), 8'h00, 0, 1, 0);
      end

      foreach (tbl[i]) begin
         cycle(tbl[i].load, tbl[i].load_val, tbl[i].en);
         chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].busy, tbl[i].zero, tbl[i].done);
      end

      // Asynchronous reset partway through a count.
      cycle(1, 8'h30, 0);
      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);
      chk_all("pre_reset", 8'h25, 1, 0, 0);
      #3;
      reset = 1'b1;
      #1;
      chk_all("async_reset", 8'h00, 0, 1, 0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 8'h00, 1);
         chk_all($sformatf("post_reset%0d", i), 8'h00, 0, 1, 0);
      end

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      begin
         logic [7:0] seq [9];
         seq = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
         cycle(1, 8'h03, 0);
         for (int i = 0; i < 9; i++) begin
            cycle(0, 8'h00, 1);
            chk_all($sformatf("reload%0d", i), seq[i], 1, 0, (i % 3 == 2) ? 1'b1 : 1'b0);
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
